// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the decode-stage hazard/forwarding unit:
// base-ISA opcode constants, the SYSTEM funct3 that carries no register
// traffic (ECALL/EBREAK), and the layout of one in-flight tag entry.
package hazard_forward_unit_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_B      = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNCT3_ECALL_EBREAK = 3'b000;

    // Tag entry field widths
    localparam int TAG_V_W  = 1;
    localparam int TAG_RD_W = 5;
    localparam int TAG_LD_W = 1;

    typedef struct packed {
        logic [TAG_V_W-1:0]  v;
        logic [TAG_RD_W-1:0] rd;
        logic [TAG_LD_W-1:0] ld;
    } tag_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_prio_sel.sv
// Priority encoder over the per-stage match vector (bit 0 = stage 1, the
// youngest). Returns the youngest matching stage, or 0 when that youngest
// producer is a load still too close to forward; in that case hazard is set.
module hazard_forward_unit_fwd_prio_sel #(
    parameter int FWD_DEPTH     = 2,
    parameter int LOAD_USE_DIST = 1,
    parameter int SEL_W         = $clog2(FWD_DEPTH + 1)
) (
    input  logic [FWD_DEPTH-1:0] match,
    input  logic [FWD_DEPTH-1:0] ld,
    output logic [SEL_W-1:0]     sel,
    output logic                 hazard
);

    logic [SEL_W-1:0] raw_sel;
    logic             hit;
    logic             hit_ld;
    int               hit_stage;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        raw_sel   = '0;
        hit       = 1'b0;
        hit_ld    = 1'b0;
        hit_stage = 0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (match[k-1]) begin
                raw_sel   = SEL_W'(k);
                hit       = 1'b1;
                hit_ld    = ld[k-1];
                hit_stage = k;
            end
        end
        hazard = hit && hit_ld && (hit_stage <= LOAD_USE_DIST);
        sel    = hazard ? '0 : raw_sel;
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard unit: tracks destination tags of the last FWD_DEPTH
// in-flight instructions, selects bypass sources for rs1/rs2 and requests
// a decode stall on load-use. Optional stall/forward statistics counters
// are built when HAZARD_STATS_EN is defined.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int FWD_DEPTH     = 2,
    parameter int LOAD_USE_DIST = 1,
    parameter int SEL_W         = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             stall_in,
    input  logic             flush,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [SEL_W-1:0] rs1_fwd_sel,
    output logic [SEL_W-1:0] rs2_fwd_sel,
    output logic             load_use_stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt
`endif
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 rd_written;
    logic                 is_load;
    tag_t                 tags [1:FWD_DEPTH];
    logic [FWD_DEPTH-1:0] match1;
    logic [FWD_DEPTH-1:0] match2;
    logic [FWD_DEPTH-1:0] ld_vec;
    logic                 haz1;
    logic                 haz2;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign rd_addr  = instr[11:7];

    // Operand usage and destination classification by opcode.
    always_comb begin
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_written = 1'b0;
        is_load    = 1'b0;
        case (opcode)
            OPC_R:     begin rs1_used = 1'b1; rs2_used = 1'b1; rd_written = 1'b1; end
            OPC_I:     begin rs1_used = 1'b1; rd_written = 1'b1; end
            OPC_LOAD:  begin rs1_used = 1'b1; rd_written = 1'b1; is_load = 1'b1; end
            OPC_S:     begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_B:     begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_JAL:   rd_written = 1'b1;
            OPC_JALR:  begin rs1_used = 1'b1; rd_written = 1'b1; end
            OPC_LUI:   rd_written = 1'b1;
            OPC_AUIPC: rd_written = 1'b1;
            OPC_SYSTEM: begin
                rs1_used   = (funct3 != FUNCT3_ECALL_EBREAK);
                rd_written = (funct3 != FUNCT3_ECALL_EBREAK);
            end
            default: ;
        endcase
    end

    // Tag pipeline: frozen on external hold, otherwise shift and insert the
    // decode instruction (or a bubble) at stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_DEPTH; k++) tags[k] <= '0;
        end else if (!stall_in) begin
            for (int k = FWD_DEPTH; k >= 2; k--) tags[k] <= tags[k-1];
            if (flush || load_use_stall || !instr_valid || !rd_written || rd_addr == 5'd0)
                tags[1] <= '0;
            else
                tags[1] <= '{v: 1'b1, rd: rd_addr, ld: is_load};
        end
    end

    // Per-stage source matches; x0 and unused sources never match.
    always_comb begin
        match1 = '0;
        match2 = '0;
        ld_vec = '0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            match1[k-1] = tags[k].v[0] && tags[k].rd == rs1_addr && rs1_used && rs1_addr != 5'd0;
            match2[k-1] = tags[k].v[0] && tags[k].rd == rs2_addr && rs2_used && rs2_addr != 5'd0;
            ld_vec[k-1] = tags[k].ld[0];
        end
    end

    hazard_forward_unit_fwd_prio_sel #(
        .FWD_DEPTH(FWD_DEPTH), .LOAD_USE_DIST(LOAD_USE_DIST), .SEL_W(SEL_W)
    ) u_sel_rs1 (
        .match(match1), .ld(ld_vec), .sel(rs1_fwd_sel), .hazard(haz1)
    );

    hazard_forward_unit_fwd_prio_sel #(
        .FWD_DEPTH(FWD_DEPTH), .LOAD_USE_DIST(LOAD_USE_DIST), .SEL_W(SEL_W)
    ) u_sel_rs2 (
        .match(match2), .ld(ld_vec), .sel(rs2_fwd_sel), .hazard(haz2)
    );

    assign load_use_stall = instr_valid && !flush && (haz1 || haz2);

`ifdef HAZARD_STATS_EN
    // Saturating counters of effective stall cycles and forwarding cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (load_use_stall && !stall_in && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (instr_valid && !stall_in && !load_use_stall &&
                (rs1_fwd_sel != '0 || rs2_fwd_sel != '0) && fwd_cnt != 32'hFFFF_FFFF)
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (FWD_DEPTH=2, LOAD_USE_DIST=1).
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        instr_valid = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
    logic        load_use_stall;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] s1;
        logic [1:0] s2;
        logic       st;
        string      name;
    } exp_t;
    exp_t sb[$];

    hazard_forward_unit #(.FWD_DEPTH(2), .LOAD_USE_DIST(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .stall_in(stall_in), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
        .load_use_stall(load_use_stall)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
        return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] r_sub(input int rd, input int rs1, input int rs2);
        return {7'b0100000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] i_lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] s_sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] b_beq(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Drive one decode cycle, check at the falling edge, then let the edge latch it.
    task automatic step(input logic [31:0] ins, input logic vld, input logic fl, input logic hold,
                        input logic [1:0] e1, input logic [1:0] e2, input logic est, input string name);
        exp_t e;
        instr = ins; instr_valid = vld; flush = fl; stall_in = hold;
        sb.push_back('{s1: e1, s2: e2, st: est, name: name});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".rs1_sel"}, 32'(rs1_fwd_sel), 32'(e.s1));
        chk({e.name, ".rs2_sel"}, 32'(rs2_fwd_sel), 32'(e.s2));
        chk({e.name, ".stall"},   32'(load_use_stall), 32'(e.st));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with a self-dependent instruction presented
        instr = r_add(5, 5, 5); instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rs1_sel", 32'(rs1_fwd_sel), 32'd0);
        chk("rst.rs2_sel", 32'(rs2_fwd_sel), 32'd0);
        chk("rst.stall",   32'(load_use_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back ALU dependency, then distance two
        step(r_add(5, 1, 2),   1, 0, 0, 0, 0, 0, "alu_prod");
        step(r_sub(6, 5, 3),   1, 0, 0, 1, 0, 0, "alu_dist1");
        step(i_addi(12, 1, 0), 1, 0, 0, 0, 0, 0, "indep");
        step(r_add(5, 1, 2),   1, 0, 0, 0, 0, 0, "alu_prod2");
        step(i_addi(12, 1, 0), 1, 0, 0, 0, 0, 0, "indep2");
        step(r_sub(6, 5, 3),   1, 0, 0, 2, 0, 0, "alu_dist2");

        // Load-use: one stall cycle, then forward from stage 2
        step(i_lw(7, 1),       1, 0, 0, 0, 0, 0, "lw");
        step(r_add(8, 7, 7),   1, 0, 0, 0, 0, 1, "lu_stall");
        step(r_add(8, 7, 7),   1, 0, 0, 2, 2, 0, "lu_after");

        // x0 and non-writers
        step(i_addi(0, 0, 1),  1, 0, 0, 0, 0, 0, "addi_x0");
        step(s_sw(0, 0),       1, 0, 0, 0, 0, 0, "sw_x0");
        step(s_sw(3, 3),       1, 0, 0, 0, 0, 0, "sw_x3");
        step(b_beq(3, 3),      1, 0, 0, 0, 0, 0, "beq_x3");

        // Youngest producer wins
        step(i_addi(9, 0, 1),  1, 0, 0, 0, 0, 0, "x9_a");
        step(i_addi(9, 0, 2),  1, 0, 0, 0, 0, 0, "x9_b");
        step(r_add(10, 9, 9),  1, 0, 0, 1, 1, 0, "youngest");

        // External hold freezes the tags
        step(i_addi(13, 0, 1), 1, 0, 0, 0, 0, 0, "x13");
        for (int i = 0; i < 3; i++)
            step(r_add(14, 13, 13), 1, 0, 1, 1, 1, 0, "hold");
        step(r_add(14, 13, 13), 1, 0, 0, 1, 1, 0, "hold_rel");

        // Flush squashes the producer
        step(i_addi(15, 0, 1),   1, 1, 0, 0, 0, 0, "flush_prod");
        step(r_add(16, 15, 15),  1, 0, 0, 0, 0, 0, "after_flush");

        // Flush masks the stall; the flushed consumer leaves a bubble
        step(i_lw(17, 0),        1, 0, 0, 0, 0, 0, "lw17");
        step(r_add(18, 17, 0),   1, 1, 0, 0, 0, 0, "lu_flushed");
        step(r_add(18, 17, 0),   1, 0, 0, 2, 0, 0, "lu_flush_next");

        // Invalid instruction never becomes a producer
        step(i_lw(19, 0),        0, 0, 0, 0, 0, 0, "lw_invalid");
        step(r_add(20, 19, 19),  1, 0, 0, 0, 0, 0, "after_invalid");

        // Load-use on rs2, then the consumer reissued as invalid
        step(i_lw(24, 0),        1, 0, 0, 0, 0, 0, "lw24");
        instr = r_add(25, 0, 24); #1;
        chk("addr.rs1", 32'(rs1_addr), 32'd0);
        chk("addr.rs2", 32'(rs2_addr), 32'd24);
        chk("addr.rd",  32'(rd_addr),  32'd25);
        step(r_add(25, 0, 24),   1, 0, 0, 0, 0, 1, "lu_rs2");
        step(r_add(25, 0, 24),   0, 0, 0, 0, 2, 0, "lu_rs2_next");

        // Asynchronous reset mid-sequence
        step(i_addi(21, 0, 1),   1, 0, 0, 0, 0, 0, "x21");
        instr = r_add(22, 21, 21); instr_valid = 1'b1;
        #2;
        chk("pre_rst.rs1_sel", 32'(rs1_fwd_sel), 32'd1);
        chk("pre_rst.rs2_sel", 32'(rs2_fwd_sel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.rs1_sel", 32'(rs1_fwd_sel), 32'd0);
        chk("async_rst.rs2_sel", 32'(rs2_fwd_sel), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(r_add(22, 21, 21),  1, 0, 0, 0, 0, 0, "post_rst");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
